// File: rtl/cdb_pkg.sv
// Shared types for the common data bus arbiter: broadcast entry layout and source encoding.
package cdb_pkg;

    // Width of the ROB tag carried in every CDB entry.
    localparam int unsigned ROB_POS_W_DEFAULT = 4;

    typedef struct packed {
        logic [ROB_POS_W_DEFAULT-1:0] rob_pos;
        logic [31:0]                  val;
        logic                         jump;
        logic [31:0]                  pc;
    } cdb_entry_t;

    localparam int unsigned CDB_ENTRY_W = $bits(cdb_entry_t);

    typedef enum logic {
        CDB_SRC_ALU = 1'b0,
        CDB_SRC_LSB = 1'b1
    } cdb_src_e;

    // Round-robin helper: the source that gets priority after s is granted.
    function automatic cdb_src_e cdb_other_src(input cdb_src_e s);
        cdb_src_e r;
        if (s == CDB_SRC_ALU) begin
            r = CDB_SRC_LSB;
        end else begin
            r = CDB_SRC_ALU;
        end
        return r;
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small circular skid FIFO holding pending CDB entries for one result producer.
// DEPTH must be a power of two so the pointers wrap naturally.
module cdb_fifo
    import cdb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [CDB_ENTRY_W-1:0]     data_i,
    input  logic                       pop_i,
    output logic [CDB_ENTRY_W-1:0]     data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW    = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [CDB_ENTRY_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;
    logic                   push_ok;
    logic                   pop_ok;

    // Overflow and underflow requests are ignored rather than corrupting state.
    assign push_ok = push_i & (count_q != FullCnt);
    assign pop_ok  = pop_i & (count_q != '0);

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

    // Next-state for pointers and occupancy; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CntW'(1);
            end else if (!push_ok && pop_ok) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Pointer and occupancy registers; reset empties the queue immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless while count is zero, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: shares one registered result broadcast between the ALU and the
// load/store buffer. Each producer feeds a skid FIFO; a round-robin grant pops one entry per
// cycle into the output register. Rollback flushes everything, rdy low freezes everything.
// Optional macro CDB_BYPASS_EN lets a result skip its empty FIFO for 1-cycle latency.
// ROB_POS_W must match cdb_pkg::ROB_POS_W_DEFAULT, which sizes the stored tag.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned ROB_POS_W = ROB_POS_W_DEFAULT,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy_i,
    input  logic                 rollback_i,
    input  logic                 alu_valid_i,
    input  logic [ROB_POS_W-1:0] alu_rob_pos_i,
    input  logic [31:0]          alu_val_i,
    input  logic                 alu_jump_i,
    input  logic [31:0]          alu_pc_i,
    output logic                 alu_ready_o,
    input  logic                 lsb_valid_i,
    input  logic [ROB_POS_W-1:0] lsb_rob_pos_i,
    input  logic [31:0]          lsb_val_i,
    output logic                 lsb_ready_o,
    output logic                 cdb_valid_o,
    output logic                 cdb_src_o,
    output logic [ROB_POS_W-1:0] cdb_rob_pos_o,
    output logic [31:0]          cdb_val_o,
    output logic                 cdb_jump_o,
    output logic [31:0]          cdb_pc_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    cdb_entry_t      alu_in, lsb_in;
    cdb_entry_t      alu_head, lsb_head;
    logic [CntW-1:0] alu_count, lsb_count;
    logic            alu_empty, lsb_empty;
    logic            alu_acc, lsb_acc;
    logic            alu_byp, lsb_byp;
    logic            alu_push, lsb_push;
    logic            alu_pop, lsb_pop;
    logic            can_go;
    logic            flush;

    cdb_src_e        prio_q, prio_d;
    logic            cdb_valid_q, cdb_valid_d;
    cdb_src_e        cdb_src_q, cdb_src_d;
    cdb_entry_t      cdb_q, cdb_d;

    // LSB results never redirect control flow, so jump/pc are stored as zero.
    assign alu_in = '{rob_pos: alu_rob_pos_i, val: alu_val_i, jump: alu_jump_i, pc: alu_pc_i};
    assign lsb_in = '{rob_pos: lsb_rob_pos_i, val: lsb_val_i, jump: 1'b0, pc: 32'h0};

    // Ready depends only on registered occupancy: a full FIFO refuses even while popping.
    assign alu_ready_o = (alu_count < DepthCnt);
    assign lsb_ready_o = (lsb_count < DepthCnt);

    assign can_go  = rdy_i & ~rollback_i;
    assign flush   = rdy_i & rollback_i;
    assign alu_acc = alu_valid_i & alu_ready_o & can_go;
    assign lsb_acc = lsb_valid_i & lsb_ready_o & can_go;

`ifdef CDB_BYPASS_EN
    // With both queues empty the output register is free this edge; the bypass goes to the
    // sole valid source, or to the priority holder when both present a result.
    assign alu_byp = alu_acc & alu_empty & lsb_empty & (~lsb_valid_i | (prio_q == CDB_SRC_ALU));
    assign lsb_byp = lsb_acc & alu_empty & lsb_empty & (~alu_valid_i | (prio_q == CDB_SRC_LSB));
`else
    assign alu_byp = 1'b0;
    assign lsb_byp = 1'b0;
`endif

    assign alu_push = alu_acc & ~alu_byp;
    assign lsb_push = lsb_acc & ~lsb_byp;

    // Round-robin among non-empty queues; a lone non-empty queue always wins.
    assign alu_pop = can_go & ~alu_empty & (lsb_empty | (prio_q == CDB_SRC_ALU));
    assign lsb_pop = can_go & ~lsb_empty & (alu_empty | (prio_q == CDB_SRC_LSB));

    cdb_fifo #(
        .DEPTH (DEPTH)
    ) u_alu_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (alu_push),
        .data_i  (alu_in),
        .pop_i   (alu_pop),
        .data_o  (alu_head),
        .count_o (alu_count),
        .empty_o (alu_empty)
    );

    cdb_fifo #(
        .DEPTH (DEPTH)
    ) u_lsb_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (lsb_push),
        .data_i  (lsb_in),
        .pop_i   (lsb_pop),
        .data_o  (lsb_head),
        .count_o (lsb_count),
        .empty_o (lsb_empty)
    );

    // Select the granted entry for the output register and advance the priority pointer.
    always_comb begin
        cdb_valid_d = 1'b0;
        cdb_src_d   = cdb_src_q;
        cdb_d       = cdb_q;
        prio_d      = prio_q;
        if (rollback_i) begin
            prio_d = CDB_SRC_ALU;
        end else if (alu_pop || alu_byp) begin
            cdb_valid_d = 1'b1;
            cdb_src_d   = CDB_SRC_ALU;
            cdb_d       = alu_pop ? alu_head : alu_in;
            prio_d      = cdb_other_src(CDB_SRC_ALU);
        end else if (lsb_pop || lsb_byp) begin
            cdb_valid_d = 1'b1;
            cdb_src_d   = CDB_SRC_LSB;
            cdb_d       = lsb_pop ? lsb_head : lsb_in;
            prio_d      = cdb_other_src(CDB_SRC_LSB);
        end
    end

    // Output and priority registers; everything holds, including valid, while rdy is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid_q <= 1'b0;
            cdb_src_q   <= CDB_SRC_ALU;
            cdb_q       <= '0;
            prio_q      <= CDB_SRC_ALU;
        end else if (rdy_i) begin
            cdb_valid_q <= cdb_valid_d;
            cdb_src_q   <= cdb_src_d;
            cdb_q       <= cdb_d;
            prio_q      <= prio_d;
        end
    end

    assign cdb_valid_o   = cdb_valid_q;
    assign cdb_src_o     = cdb_src_q;
    assign cdb_rob_pos_o = cdb_q.rob_pos;
    assign cdb_val_o     = cdb_q.val;
    assign cdb_jump_o    = cdb_q.jump;
    assign cdb_pc_o      = cdb_q.pc;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter (DEPTH=2, ROB_POS_W=4) with hand-derived expectations.
module tb_cdb_arbiter;

`ifdef CDB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        rollback;
    logic        alu_valid;
    logic [3:0]  alu_rob_pos;
    logic [31:0] alu_val;
    logic        alu_jump;
    logic [31:0] alu_pc;
    logic        alu_ready;
    logic        lsb_valid;
    logic [3:0]  lsb_rob_pos;
    logic [31:0] lsb_val;
    logic        lsb_ready;
    logic        cdb_valid;
    logic        cdb_src;
    logic [3:0]  cdb_rob_pos;
    logic [31:0] cdb_val;
    logic        cdb_jump;
    logic [31:0] cdb_pc;
    logic [70:0] obs;

    int n_checks = 0;
    int n_pass   = 0;

    assign obs = {cdb_valid, cdb_src, cdb_rob_pos, cdb_val, cdb_jump, cdb_pc};

    cdb_arbiter #(
        .ROB_POS_W (4),
        .DEPTH     (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rdy_i         (rdy),
        .rollback_i    (rollback),
        .alu_valid_i   (alu_valid),
        .alu_rob_pos_i (alu_rob_pos),
        .alu_val_i     (alu_val),
        .alu_jump_i    (alu_jump),
        .alu_pc_i      (alu_pc),
        .alu_ready_o   (alu_ready),
        .lsb_valid_i   (lsb_valid),
        .lsb_rob_pos_i (lsb_rob_pos),
        .lsb_val_i     (lsb_val),
        .lsb_ready_o   (lsb_ready),
        .cdb_valid_o   (cdb_valid),
        .cdb_src_o     (cdb_src),
        .cdb_rob_pos_o (cdb_rob_pos),
        .cdb_val_o     (cdb_val),
        .cdb_jump_o    (cdb_jump),
        .cdb_pc_o      (cdb_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected broadcast bundle for ALU item i / LSB item i.
    function automatic logic [70:0] exp_a(input int i);
        return {1'b1, 1'b0, 4'(i), 32'hA000 + 32'(i), 1'(i & 1), 32'h100 + 32'(4 * i)};
    endfunction

    function automatic logic [70:0] exp_l(input int i);
        return {1'b1, 1'b1, 4'(8 + i), 32'hB000 + 32'(i), 1'b0, 32'h0};
    endfunction

    task automatic drive_a(input logic v, input int i);
        alu_valid   = v;
        alu_rob_pos = 4'(i);
        alu_val     = 32'hA000 + 32'(i);
        alu_jump    = 1'(i & 1);
        alu_pc      = 32'h100 + 32'(4 * i);
    endtask

    task automatic drive_l(input logic v, input int i);
        lsb_valid   = v;
        lsb_rob_pos = 4'(8 + i);
        lsb_val     = 32'hB000 + 32'(i);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        rdy      = 1'b1;
        rollback = 1'b0;
        drive_a(1'b0, 0);
        drive_l(1'b0, 0);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        rdy      = 1'b1;
        rollback = 1'b0;
        drive_a(1'b0, 0);
        drive_l(1'b0, 0);
        #12;
        n_checks++;
        if (obs !== 71'h0) $display("FAIL reset_outputs: got %h want 0", obs);
        else n_pass++;
        n_checks++;
        if ({alu_ready, lsb_ready} !== 2'b11)
            $display("FAIL reset_ready: got %b want 11", {alu_ready, lsb_ready});
        else n_pass++;
        #1;
        rst_n = 1'b1;
        step();
        n_checks++;
        if (obs !== 71'h0) $display("FAIL reset_idle: got %h want 0", obs);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [70:0] full;
        logic [70:0] held;
        full = {1'b1, 1'b0, 4'd3, 32'h1234, 1'b1, 32'h80};
        held = {1'b0, 1'b0, 4'd3, 32'h1234, 1'b1, 32'h80};
        apply_reset();
        alu_valid   = 1'b1;
        alu_rob_pos = 4'd3;
        alu_val     = 32'h1234;
        alu_jump    = 1'b1;
        alu_pc      = 32'h80;
        step();
        drive_a(1'b0, 0);
        n_checks++;
        if (obs !== (Byp ? full : 71'h0)) $display("FAIL single_e0: got %h want %h", obs,
                                                  Byp ? full : 71'h0);
        else n_pass++;
        step();
        n_checks++;
        if (obs !== (Byp ? held : full)) $display("FAIL single_e1: got %h want %h", obs,
                                                 Byp ? held : full);
        else n_pass++;
        step();
        n_checks++;
        if (obs !== held) $display("FAIL single_hold: got %h want %h", obs, held);
        else n_pass++;
    endtask

    // ALU alone: one accept and one broadcast per cycle, ready never drops.
    task automatic test_back_to_back();
        apply_reset();
        drive_a(1'b1, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            if (k < 3) drive_a(1'b1, k + 1);
            else drive_a(1'b0, 0);
            n_checks++;
            if (k >= 1 && k <= 4) begin
                if (obs !== exp_a(k - 1))
                    $display("FAIL b2b_data[%0d]: got %h want %h", k, obs, exp_a(k - 1));
                else n_pass++;
            end else begin
                if (cdb_valid !== 1'b0) $display("FAIL b2b_idle[%0d]: got %b want 0", k, cdb_valid);
                else n_pass++;
            end
            n_checks++;
            if (alu_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", k, alu_ready);
            else n_pass++;
        end
    endtask

    // Both sources valid for 8 edges: readies alternate once a FIFO fills, grants alternate.
    task automatic test_contention();
        logic [70:0] exp_q [$];
        logic [7:0]  exp_ar;
        logic [7:0]  exp_lr;
        int          ai;
        int          li;
        int          k;
        exp_ar = 8'b0101_0111;
        exp_lr = 8'b1010_1011;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exp_a(i));
            exp_q.push_back(exp_l(i));
        end
        apply_reset();
        ai = 0;
        li = 0;
        k  = 0;
        drive_a(1'b1, 0);
        drive_l(1'b1, 0);
        for (int e = 0; e < 13; e++) begin
            if (e < 8) begin
                n_checks++;
                if ({alu_ready, lsb_ready} !== {exp_ar[e], exp_lr[e]})
                    $display("FAIL cont_ready[%0d]: got %b want %b", e, {alu_ready, lsb_ready},
                             {exp_ar[e], exp_lr[e]});
                else n_pass++;
            end
            step();
            if (e < 8) begin
                if (exp_ar[e]) ai++;
                if (exp_lr[e]) li++;
            end
            if (e < 7) begin
                drive_a(1'b1, ai);
                drive_l(1'b1, li);
            end else begin
                drive_a(1'b0, 0);
                drive_l(1'b0, 0);
            end
            if (cdb_valid === 1'b1) begin
                n_checks++;
                if (k >= 10) $display("FAIL cont_extra[%0d]: got %h want none", k, obs);
                else if (obs !== exp_q[k])
                    $display("FAIL cont_data[%0d]: got %h want %h", k, obs, exp_q[k]);
                else n_pass++;
                k++;
            end
        end
        n_checks++;
        if (k !== 10) $display("FAIL cont_count: got %0d want 10", k);
        else n_pass++;
    endtask

    // Rollback while LSB holds priority: queues dropped, priority back to ALU.
    task automatic test_rollback();
        apply_reset();
        drive_a(1'b1, 5);
        drive_l(1'b1, 5);
        step();
        drive_a(1'b1, 6);
        drive_l(1'b1, 6);
        step();
        n_checks++;
        if (obs !== exp_a(5)) $display("FAIL rb_pre: got %h want %h", obs, exp_a(5));
        else n_pass++;
        drive_a(1'b1, 7);
        drive_l(1'b1, 7);
        rollback = 1'b1;
        step();
        rollback = 1'b0;
        n_checks++;
        if ({cdb_valid, alu_ready, lsb_ready} !== 3'b011)
            $display("FAIL rb_flush: got %b want 011", {cdb_valid, alu_ready, lsb_ready});
        else n_pass++;
        drive_a(1'b1, 8);
        drive_l(1'b1, 8);
        step();
        drive_a(1'b0, 0);
        drive_l(1'b0, 0);
        n_checks++;
        if (cdb_valid !== 1'b0) $display("FAIL rb_gap: got %b want 0", cdb_valid);
        else n_pass++;
        step();
        n_checks++;
        if (obs !== exp_a(8)) $display("FAIL rb_first: got %h want %h", obs, exp_a(8));
        else n_pass++;
        step();
        n_checks++;
        if (obs !== exp_l(8)) $display("FAIL rb_second: got %h want %h", obs, exp_l(8));
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (cdb_valid !== 1'b0) $display("FAIL rb_drained[%0d]: got %b want 0", c, cdb_valid);
            else n_pass++;
        end
    endtask

    // rdy low freezes outputs, counts and accepts; order resumes afterwards.
    task automatic test_rdy_freeze();
        apply_reset();
        drive_a(1'b1, 20);
        drive_l(1'b1, 20);
        step();
        drive_a(1'b1, 21);
        drive_l(1'b1, 21);
        step();
        drive_a(1'b1, 22);
        drive_l(1'b0, 0);
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (obs !== exp_a(20)) $display("FAIL frz_out[%0d]: got %h want %h", c, obs, exp_a(20));
            else n_pass++;
            n_checks++;
            if ({alu_ready, lsb_ready} !== 2'b10)
                $display("FAIL frz_ready[%0d]: got %b want 10", c, {alu_ready, lsb_ready});
            else n_pass++;
        end
        drive_a(1'b0, 0);
        rdy = 1'b1;
        step();
        n_checks++;
        if (obs !== exp_l(20)) $display("FAIL frz_res0: got %h want %h", obs, exp_l(20));
        else n_pass++;
        step();
        n_checks++;
        if (obs !== exp_a(21)) $display("FAIL frz_res1: got %h want %h", obs, exp_a(21));
        else n_pass++;
        step();
        n_checks++;
        if (obs !== exp_l(21)) $display("FAIL frz_res2: got %h want %h", obs, exp_l(21));
        else n_pass++;
        step();
        n_checks++;
        if (cdb_valid !== 1'b0) $display("FAIL frz_end: got %b want 0", cdb_valid);
        else n_pass++;
    endtask

    // Reset pulsed between edges clears outputs and queues without a clock.
    task automatic test_async_reset();
        apply_reset();
        drive_a(1'b1, 30);
        drive_l(1'b1, 30);
        step();
        drive_a(1'b1, 31);
        drive_l(1'b1, 31);
        step();
        drive_a(1'b0, 0);
        drive_l(1'b0, 0);
        n_checks++;
        if ({obs, alu_ready, lsb_ready} !== {exp_a(30), 2'b10})
            $display("FAIL arst_pre: got %h want %h", {obs, alu_ready, lsb_ready},
                     {exp_a(30), 2'b10});
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== 71'h0) $display("FAIL arst_out: got %h want 0", obs);
        else n_pass++;
        n_checks++;
        if ({alu_ready, lsb_ready} !== 2'b11)
            $display("FAIL arst_ready: got %b want 11", {alu_ready, lsb_ready});
        else n_pass++;
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (cdb_valid !== 1'b0) $display("FAIL arst_empty[%0d]: got %b want 0", c, cdb_valid);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_contention();
        test_rollback();
        test_rdy_freeze();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish before 100000");
        $fatal(1);
    end

endmodule
